// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter FSM codes, well-known command bytes, default timing.
// Used by the host transmitter and the receive path.
package ps2_pkg;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] INHIBIT   = 3'd1;
  localparam logic [2:0] REQ       = 3'd2;
  localparam logic [2:0] DATA      = 3'd3;
  localparam logic [2:0] PARITY    = 3'd4;
  localparam logic [2:0] ACK       = 3'd5;
  localparam logic [2:0] WAIT_IDLE = 3'd6;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ECHO     = 8'hEE;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] ACK_BYTE     = 8'hFA;

  // 100 us inhibit and 15 ms device timeout at a 50 MHz core clock
  localparam int DEF_INHIBIT_CYCLES = 5000;
  localparam int DEF_TIMEOUT_CYCLES = 750000;
  localparam int DEF_SYNC_STAGES    = 2;

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_command_tx_if.sv
// Command handshake and transfer status between a requester and the PS/2 transmitter.
// master issues commands; slave is the transmitter.
interface ps2_command_tx_if;
  logic [7:0] cmd_data;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       busy;
  logic       tx_done;
  logic       tx_error;
  logic       ack_ok;

  modport master (
    output cmd_data, cmd_valid,
    input  cmd_ready, busy, tx_done, tx_error, ack_ok
  );

  modport slave (
    input  cmd_data, cmd_valid,
    output cmd_ready, busy, tx_done, tx_error, ack_ok
  );
endinterface

// File: rtl/ps2_edge_sync.sv
// Synchronizes raw PS/2 clock/data and flags clock falling edges; SYNC_STAGES+1 cycles pin to action.
// Registers idle high so reset release never produces a false edge.
module ps2_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2_clk_in,
  input  logic ps2_data_in,
  output logic clk_sync,
  output logic data_sync,
  output logic clk_fall
);
  logic [SYNC_STAGES-1:0] clk_sr;
  logic [SYNC_STAGES-1:0] data_sr;
  logic                   clk_prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_sr   <= '1;
      data_sr  <= '1;
      clk_prev <= 1'b1;
    end else begin
      clk_sr   <= {clk_sr[SYNC_STAGES-2:0], ps2_clk_in};
      data_sr  <= {data_sr[SYNC_STAGES-2:0], ps2_data_in};
      clk_prev <= clk_sr[SYNC_STAGES-1];
    end
  end

  assign clk_sync  = clk_sr[SYNC_STAGES-1];
  assign data_sync = data_sr[SYNC_STAGES-1];
  assign clk_fall  = clk_prev & ~clk_sync;
endmodule

// File: rtl/ps2_command_tx.sv
// Host-to-device PS/2 command transmitter: request-to-send, 11-clock frame, device ack check.
// Takes a byte only in IDLE (no queueing); line enables update the cycle after a detected clock fall.
module ps2_command_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int SYNC_STAGES    = DEF_SYNC_STAGES
) (
  input  logic            clk,
  input  logic            reset,
  ps2_command_tx_if.slave cmd,
  input  logic            ps2_clk_in,
  input  logic            ps2_data_in,
  output logic            ps2_clk_oe,
  output logic            ps2_data_oe
);
  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [INH_W-1:0] INH_START = INH_W'(INHIBIT_CYCLES - 2);
  localparam logic [INH_W-1:0] INH_LAST  = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_MAX    = TO_W'(TIMEOUT_CYCLES);

  logic [2:0]       state;
  logic [7:0]       cmd_q;
  logic             parity_q;
  logic [3:0]       bit_idx;
  logic [INH_W-1:0] inh_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic             tx_done_q;
  logic             tx_error_q;
  logic             ack_ok_q;
  logic             clk_sync;
  logic             data_sync;
  logic             clk_fall;

  ps2_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk        (clk),
    .reset      (reset),
    .ps2_clk_in (ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .clk_sync   (clk_sync),
    .data_sync  (data_sync),
    .clk_fall   (clk_fall)
  );

  assign cmd.cmd_ready = (state == IDLE);
  assign cmd.busy      = (state != IDLE);
  assign cmd.tx_done   = tx_done_q;
  assign cmd.tx_error  = tx_error_q;
  assign cmd.ack_ok    = ack_ok_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cmd_q       <= '0;
      parity_q    <= 1'b0;
      bit_idx     <= '0;
      inh_cnt     <= '0;
      to_cnt      <= '0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      tx_done_q   <= 1'b0;
      tx_error_q  <= 1'b0;
      ack_ok_q    <= 1'b0;
    end else begin
      tx_done_q  <= 1'b0;
      tx_error_q <= 1'b0;
      if (to_cnt != TO_MAX) to_cnt <= to_cnt + 1'b1;

      case (state)
        IDLE: begin
          if (cmd.cmd_valid) begin
            cmd_q      <= cmd.cmd_data;
            parity_q   <= odd_parity(cmd.cmd_data);
            bit_idx    <= '0;
            inh_cnt    <= '0;
            ps2_clk_oe <= 1'b1;
            state      <= INHIBIT;
          end
        end
        INHIBIT: begin
          inh_cnt <= inh_cnt + 1'b1;
          // start bit overlaps the final inhibit cycle
          if (inh_cnt == INH_START) ps2_data_oe <= 1'b1;
          if (inh_cnt == INH_LAST) begin
            ps2_clk_oe <= 1'b0;
            to_cnt     <= '0;
            state      <= REQ;
          end
        end
        default: begin
          if (clk_fall) to_cnt <= '0;
          if (to_cnt == TO_MAX) begin
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            ack_ok_q    <= 1'b0;
            tx_error_q  <= 1'b1;
            state       <= IDLE;
          end else begin
            case (state)
              REQ: if (clk_fall) begin
                ps2_data_oe <= ~cmd_q[0];
                bit_idx     <= 4'd1;
                state       <= DATA;
              end
              DATA: if (clk_fall) begin
                if (bit_idx == 4'd8) begin
                  ps2_data_oe <= ~parity_q;
                  bit_idx     <= 4'd9;
                  state       <= PARITY;
                end else begin
                  ps2_data_oe <= ~cmd_q[bit_idx[2:0]];
                  bit_idx     <= bit_idx + 1'b1;
                end
              end
              PARITY: if (clk_fall) begin
                ps2_data_oe <= 1'b0;
                bit_idx     <= 4'd10;
                state       <= ACK;
              end
              ACK: if (clk_fall) begin
                ack_ok_q <= ~data_sync;
                bit_idx  <= 4'd11;
                state    <= WAIT_IDLE;
              end
              WAIT_IDLE: if (clk_sync && data_sync) begin
                tx_done_q  <= ack_ok_q;
                tx_error_q <= ~ack_ok_q;
                state      <= IDLE;
              end
              default: state <= IDLE;
            endcase
          end
        end
      endcase
    end
  end
endmodule

// File: doc/ps2_command_tx.md
Name: ps2_command_tx

Overview:
Host-to-device PS/2 transmitter. It sends one command byte (for example 0xED set-LEDs, 0xFF reset) from the FPGA to the keyboard. It uses the standard request-to-send sequence and drives both lines open-drain through active-high pull-low enables. It sits beside the scancode decoder in the keyboard top level; the decoder ignores the bus while `busy` is high.

Parameters:
- INHIBIT_CYCLES, 5000: cycles `ps2_clk` is held low for request-to-send (100 us at 50 MHz).
- TIMEOUT_CYCLES, 750000: maximum cycles between device clock falling edges before abort (15 ms at 50 MHz).
- SYNC_STAGES, 2: synchronizer depth on `ps2_clk_in` and `ps2_data_in` (minimum 2).

Ports:
- clk  in  1  system clock, 50 MHz
- reset  in  1  asynchronous, active-low reset (0 = reset)
- cmd_data  in  8  command byte
- cmd_valid  in  1  command request
- cmd_ready  out  1  high in IDLE; a byte is accepted when cmd_valid & cmd_ready
- ps2_clk_in  in  1  raw PS/2 clock line
- ps2_data_in  in  1  raw PS/2 data line
- ps2_clk_oe  out  1  1 = pull PS/2 clock low, 0 = release
- ps2_data_oe  out  1  1 = pull PS/2 data low, 0 = release
- busy  out  1  high in every state except IDLE
- tx_done  out  1  one-cycle pulse: byte acknowledged by device
- tx_error  out  1  one-cycle pulse: timeout or missing ack
- ack_ok  out  1  level; result of last transfer, holds until next transfer ends

Behaviour:
- Reset values (asserted asynchronously): state IDLE, ps2_clk_oe=0, ps2_data_oe=0, busy=0, cmd_ready=1, tx_done=0, tx_error=0, ack_ok=0, all counters 0.
- Falling edge = synchronized clock previous=1, current=0. This adds SYNC_STAGES+1 cycles of latency from the pin.
- Accept: on cmd_valid & cmd_ready, latch cmd_data, compute parity = ~^cmd_data (odd), go to INHIBIT. cmd_valid while busy is ignored; nothing is queued.
- INHIBIT:
  - clk_oe=1 for exactly INHIBIT_CYCLES cycles.
  - On the last cycle, data_oe goes to 1 (start bit).
  - Next cycle: clk_oe=0, go to REQ.
- REQ: data_oe=1. Wait for a falling edge.
  - Edge 1 drives bit0: data_oe=~cmd[0], bit index 1, go to DATA.
- DATA: on each falling edge drive data_oe=~cmd[idx], idx++.
  - Edges 2..8 drive bits 1..7.
  - Edge 9 drives data_oe=~parity, go to PARITY.
- PARITY: edge 10 sets data_oe=0 (stop bit = released), go to ACK.
- ACK: on edge 11, sample synchronized data.
  - 0 → ack_ok=1.
  - 1 → ack_ok=0.
  - Either way go to WAIT_IDLE.
- WAIT_IDLE: wait until the synchronized clock and data are both 1.
  - If ack_ok=1: pulse tx_done, go to IDLE.
  - If ack_ok=0: pulse tx_error, go to IDLE.
- Timeout:
  - In REQ, DATA, PARITY, ACK and WAIT_IDLE a counter clears on each falling edge and on state entry.
  - When it reaches TIMEOUT_CYCLES: clk_oe=0, data_oe=0, ack_ok=0, pulse tx_error, go to IDLE.
  - Counter width is $clog2(TIMEOUT_CYCLES+1) and it saturates.
- Outputs are registered; oe changes occur on the cycle after the edge is detected.
- tx_done and tx_error are never asserted together.
- Reset mid-transfer: both lines are released immediately (asynchronous) and the latched byte is discarded.
- Counts are strict. The INHIBIT count uses its own counter. The bit index is 4 bits and covers edges 1..11 only.

Decomposition:
- Package ps2_pkg holds:
  - state encoding: IDLE, INHIBIT, REQ, DATA, PARITY, ACK, WAIT_IDLE
  - command constants: CMD_SET_LEDS=8'hED, CMD_ECHO=8'hEE, CMD_RESET=8'hFF
  - device ack constant: ACK_BYTE=8'hFA
  - default timing constants
- Sub-module ps2_edge_sync: synchronizer plus falling-edge detector, parameterized by SYNC_STAGES. It is shared with the receive path.

Test Plan:
1. cmd_data=0xED:
   - clk_oe high exactly 5000 cycles; data_oe rises on cycle 5000 of INHIBIT.
   - The device model clocks at 12.5 kHz and samples on rising edges.
   - Sampled bits are 1,0,1,1,0,1,1,1, then parity 1, then stop 1.
   - Model drives ack 0 at edge 11 → tx_done one cycle, ack_ok=1, busy=0.
2. cmd_data=0x01 → parity bit 0. cmd_data=0xFF → parity bit 1. Data bits match LSB-first.
3. Device leaves data high at edge 11 → tx_error one cycle, tx_done=0, ack_ok=0.
4. Device never clocks after request-to-send → after TIMEOUT_CYCLES in REQ: tx_error, clk_oe=0, data_oe=0, cmd_ready=1.
5. Reset driven to 0 after edge 4 in DATA:
   - Both oe go to 0 before the next clk edge; busy=0.
   - After release, 0xFF transmits correctly.
6. cmd_valid held high across a transfer with cmd_data changing → the second byte is accepted only in the cycle after returning to IDLE; the first byte's bits are unaffected.
